pong_ball_engine: RTL and testbench

- Upstream stage of the Pong renderer. Owns ball position, direction, serve/score sequencing and scores.
- Drives square_xpos/square_ypos/sq_shown directly into the renderer.
- Consumes paddle positions from the paddle controllers.
- Updates once per frame on frame_tick, which is pulsed during vertical blanking, so sprites never tear.

---
 rtl/pong_pkg.sv | 42 ++++
 rtl/pong_ball_engine.sv | 204 ++++++++++++++++++++
 tb/tb_pong_ball_engine.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared Pong definitions: screen and sprite geometry, ball tuning constants,
// FSM and direction encodings, and small arithmetic helpers.
package pong_pkg;

  localparam logic [10:0] H_VIDEO       = 11'd640;
  localparam logic [10:0] V_VIDEO       = 11'd480;
  localparam logic [10:0] SQUARE_WIDTH  = 11'd16;
  localparam logic [10:0] PADDLE_WIDTH  = 11'd12;
  localparam logic [10:0] PADDLE_HEIGHT = 11'd96;

  localparam logic [3:0]  SPEED_X      = 4'd3;
  localparam logic [10:0] SPEED_Y      = 11'd2;
  localparam logic [5:0]  SERVE_FRAMES = 6'd60;
  localparam logic [5:0]  SCORE_FRAMES = 6'd45;

  localparam logic [10:0] X_CENTRE = (H_VIDEO - SQUARE_WIDTH) >> 1;
  localparam logic [10:0] Y_CENTRE = (V_VIDEO - SQUARE_WIDTH) >> 1;
  // Largest top-left coordinates that keep the whole ball on screen.
  localparam logic [10:0] X_LIMIT  = H_VIDEO - 11'd1 - SQUARE_WIDTH;
  localparam logic [10:0] Y_LIMIT  = V_VIDEO - 11'd1 - SQUARE_WIDTH;

  typedef enum logic [1:0] {
    SERVE  = 2'd0,
    PLAY   = 2'd1,
    SCORED = 2'd2
  } state_t;

  // DIR_NEG is left/up, DIR_POS is right/down.
  typedef enum logic {
    DIR_NEG = 1'b0,
    DIR_POS = 1'b1
  } dir_t;

  function automatic logic [9:0] clamp10(input logic [10:0] v, input logic [10:0] lim);
    return (v > lim) ? lim[9:0] : v[9:0];
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/pong_ball_engine.sv
// Pong ball engine: per-frame ball motion, paddle/wall bounces, serve/score sequencing.
// Define PONG_BALL_SPEEDUP_EN to make each paddle hit speed the ball up horizontally.
module pong_ball_engine
  import pong_pkg::*;
(
  input  logic       clk_0,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [9:0] paddle1_xpos,
  input  logic [9:0] paddle1_ypos,
  input  logic [9:0] paddle2_xpos,
  input  logic [9:0] paddle2_ypos,
  output logic [9:0] square_xpos,
  output logic [9:0] square_ypos,
  output logic       sq_shown,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       point_p1,
  output logic       point_p2
);

  state_t     state_reg, state_next;
  logic [9:0] x_reg, x_next;
  logic [9:0] y_reg, y_next;
  logic       shown_reg, shown_next;
  dir_t       dir_x_reg, dir_x_next;
  dir_t       dir_y_reg, dir_y_next;
  logic [5:0] count_reg, count_next;
  logic [3:0] score_p1_reg, score_p1_next;
  logic [3:0] score_p2_reg, score_p2_next;
  logic       point_p1_reg, point_p1_next;
  logic       point_p2_reg, point_p2_next;

  logic [10:0] spd;
  logic [10:0] x_w, y_w, p1x_w, p1y_w, p2x_w, p2y_w;
  logic        overlap1, overlap2;
  logic        hit_left, hit_right, miss_left, miss_right;
  logic        serve_done, score_done;

  // All comparisons run at 11 bits so x+width+speed never wraps.
  assign x_w   = {1'b0, x_reg};
  assign y_w   = {1'b0, y_reg};
  assign p1x_w = {1'b0, paddle1_xpos};
  assign p1y_w = {1'b0, paddle1_ypos};
  assign p2x_w = {1'b0, paddle2_xpos};
  assign p2y_w = {1'b0, paddle2_ypos};

  assign serve_done = (count_reg == SERVE_FRAMES - 6'd1);
  assign score_done = (count_reg == SCORE_FRAMES - 6'd1);

  assign overlap1 = (y_w + SQUARE_WIDTH >= p1y_w) && (y_w <= p1y_w + PADDLE_HEIGHT);
  assign overlap2 = (y_w + SQUARE_WIDTH >= p2y_w) && (y_w <= p2y_w + PADDLE_HEIGHT);

  // Hit means the ball would cross the paddle face during this frame's step.
  assign hit_left   = (dir_x_reg == DIR_NEG) && (x_w > p1x_w + PADDLE_WIDTH) &&
                      (x_w <= p1x_w + PADDLE_WIDTH + spd) && overlap1;
  assign miss_left  = (dir_x_reg == DIR_NEG) && !hit_left && (x_w < spd);
  assign hit_right  = (dir_x_reg == DIR_POS) && (x_w + SQUARE_WIDTH < p2x_w) &&
                      (x_w + SQUARE_WIDTH + spd >= p2x_w) && overlap2;
  assign miss_right = (dir_x_reg == DIR_POS) && !hit_right &&
                      (x_w + SQUARE_WIDTH + spd > H_VIDEO - 11'd1);

`ifdef PONG_BALL_SPEEDUP_EN
  localparam logic [3:0] MAX_SPEED = 4'd8;
  logic [3:0] speed_reg, speed_next;

  always_comb begin
    speed_next = speed_reg;
    if (frame_tick) begin
      if (state_reg == PLAY && (hit_left || hit_right))
        speed_next = (speed_reg >= MAX_SPEED) ? MAX_SPEED : speed_reg + 4'd1;
      else if (state_reg == SCORED && score_done)
        speed_next = SPEED_X;
    end
  end

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) speed_reg <= SPEED_X;
    else      speed_reg <= speed_next;
  end

  assign spd = {7'd0, speed_reg};
`else
  assign spd = {7'd0, SPEED_X};
`endif

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      state_reg    <= SERVE;
      x_reg        <= X_CENTRE[9:0];
      y_reg        <= Y_CENTRE[9:0];
      shown_reg    <= 1'b1;
      dir_x_reg    <= DIR_POS;
      dir_y_reg    <= DIR_POS;
      count_reg    <= '0;
      score_p1_reg <= '0;
      score_p2_reg <= '0;
      point_p1_reg <= 1'b0;
      point_p2_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      x_reg        <= x_next;
      y_reg        <= y_next;
      shown_reg    <= shown_next;
      dir_x_reg    <= dir_x_next;
      dir_y_reg    <= dir_y_next;
      count_reg    <= count_next;
      score_p1_reg <= score_p1_next;
      score_p2_reg <= score_p2_next;
      point_p1_reg <= point_p1_next;
      point_p2_reg <= point_p2_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (frame_tick) begin
      case (state_reg)
        SERVE:   if (serve_done) state_next = PLAY;
        PLAY:    if (miss_left || miss_right) state_next = SCORED;
        SCORED:  if (score_done) state_next = SERVE;
        default: state_next = SERVE;
      endcase
    end
  end

  always_comb begin
    x_next        = x_reg;
    y_next        = y_reg;
    shown_next    = shown_reg;
    dir_x_next    = dir_x_reg;
    dir_y_next    = dir_y_reg;
    count_next    = count_reg;
    score_p1_next = score_p1_reg;
    score_p2_next = score_p2_reg;
    point_p1_next = 1'b0;
    point_p2_next = 1'b0;
    if (frame_tick) begin
      case (state_reg)
        SERVE: count_next = serve_done ? 6'd0 : count_reg + 6'd1;
        PLAY: begin
          if (miss_left) begin
            // Position freezes where the ball left the field.
            score_p2_next = sat_inc4(score_p2_reg);
            point_p2_next = 1'b1;
            shown_next    = 1'b0;
            dir_x_next    = DIR_NEG;
          end else if (miss_right) begin
            score_p1_next = sat_inc4(score_p1_reg);
            point_p1_next = 1'b1;
            shown_next    = 1'b0;
            dir_x_next    = DIR_POS;
          end else begin
            if (dir_y_reg == DIR_POS) begin
              if (y_w + SQUARE_WIDTH + SPEED_Y > V_VIDEO - 11'd1) begin
                y_next     = Y_LIMIT[9:0];
                dir_y_next = DIR_NEG;
              end else begin
                y_next = clamp10(y_w + SPEED_Y, Y_LIMIT);
              end
            end else if (y_w < SPEED_Y) begin
              y_next     = '0;
              dir_y_next = DIR_POS;
            end else begin
              y_next = clamp10(y_w - SPEED_Y, Y_LIMIT);
            end

            if (hit_left) begin
              x_next     = clamp10(p1x_w + PADDLE_WIDTH + 11'd1, X_LIMIT);
              dir_x_next = DIR_POS;
            end else if (dir_x_reg == DIR_NEG) begin
              x_next = clamp10(x_w - spd, X_LIMIT);
            end else if (hit_right) begin
              x_next     = clamp10(p2x_w - SQUARE_WIDTH - 11'd1, X_LIMIT);
              dir_x_next = DIR_NEG;
            end else begin
              x_next = clamp10(x_w + spd, X_LIMIT);
            end
          end
        end
        SCORED: begin
          if (score_done) begin
            count_next = '0;
            x_next     = X_CENTRE[9:0];
            y_next     = Y_CENTRE[9:0];
            shown_next = 1'b1;
          end else begin
            count_next = count_reg + 6'd1;
          end
        end
        default: count_next = '0;
      endcase
    end
  end

  assign square_xpos = x_reg;
  assign square_ypos = y_reg;
  assign sq_shown    = shown_reg;
  assign score_p1    = score_p1_reg;
  assign score_p2    = score_p2_reg;
  assign point_p1    = point_p1_reg;
  assign point_p2    = point_p2_reg;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed testbench for pong_ball_engine: serve timing, wall and paddle bounces,
// scoring, score saturation and asynchronous reset mid-play / mid-score.
module tb_pong_ball_engine;

  logic       clk_0 = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic [9:0] paddle1_xpos = 10'd20;
  logic [9:0] paddle1_ypos = 10'd100;
  logic [9:0] paddle2_xpos = 10'd600;
  logic [9:0] paddle2_ypos = 10'd380;
  logic [9:0] square_xpos, square_ypos;
  logic       sq_shown;
  logic [3:0] score_p1, score_p2;
  logic       point_p1, point_p2;

  int checks = 0;
  int errors = 0;

  pong_ball_engine dut (
    .clk_0       (clk_0),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .paddle1_xpos(paddle1_xpos),
    .paddle1_ypos(paddle1_ypos),
    .paddle2_xpos(paddle2_xpos),
    .paddle2_ypos(paddle2_ypos),
    .square_xpos (square_xpos),
    .square_ypos (square_ypos),
    .sq_shown    (sq_shown),
    .score_p1    (score_p1),
    .score_p2    (score_p2),
    .point_p1    (point_p1),
    .point_p2    (point_p2)
  );

  always #20 clk_0 = ~clk_0;

  // One frame: tick high for exactly one rising edge; returns on the next falling edge.
  task automatic tick();
    @(negedge clk_0);
    frame_tick = 1'b1;
    @(negedge clk_0);
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    #7 rst = 1'b0;
    #1;
    checks++;
    if (square_xpos !== 10'd312 || square_ypos !== 10'd232 || sq_shown !== 1'b1) begin
      $display("FAIL reset_pos x=%0d y=%0d shown=%0b expected 312 232 1", square_xpos, square_ypos, sq_shown);
      errors++;
    end
    checks++;
    if (score_p1 !== 4'd0 || score_p2 !== 4'd0 || point_p1 !== 1'b0 || point_p2 !== 1'b0) begin
      $display("FAIL reset_score s1=%0d s2=%0d p1=%0b p2=%0b expected 0 0 0 0", score_p1, score_p2, point_p1, point_p2);
      errors++;
    end
    repeat (3) @(negedge clk_0);
    rst = 1'b1;
    repeat (4) @(negedge clk_0);
    checks++;
    if (square_xpos !== 10'd312 || square_ypos !== 10'd232) begin
      $display("FAIL idle_hold x=%0d y=%0d expected 312 232", square_xpos, square_ypos);
      errors++;
    end
    $display("test_reset: x=%0d y=%0d shown=%0b", square_xpos, square_ypos, sq_shown);
  endtask

  // 60 stationary serve frames, then the first move on frame 61.
  task automatic test_serve(input logic [9:0] exp_x, input logic [9:0] exp_y, input string tag);
    for (int i = 1; i <= 60; i++) begin
      tick();
      checks++;
      if (square_xpos !== 10'd312 || square_ypos !== 10'd232 || sq_shown !== 1'b1) begin
        $display("FAIL %s_hold tick=%0d x=%0d y=%0d shown=%0b expected 312 232 1", tag, i, square_xpos, square_ypos, sq_shown);
        errors++;
      end
    end
    tick();
    checks++;
    if (square_xpos !== exp_x || square_ypos !== exp_y) begin
      $display("FAIL %s_launch x=%0d y=%0d expected %0d %0d", tag, square_xpos, square_ypos, exp_x, exp_y);
      errors++;
    end
    $display("%s: launch x=%0d y=%0d", tag, square_xpos, square_ypos);
  endtask

  task automatic test_wall_bounce();
    ticks(89);
    checks++;
    if (square_xpos !== 10'd582) begin
      $display("FAIL pre_paddle2 x=%0d expected 582", square_xpos);
      errors++;
    end
    tick();
    checks++;
    if (square_xpos !== 10'd583 || square_ypos !== 10'd414) begin
      $display("FAIL paddle2_hit x=%0d y=%0d expected 583 414", square_xpos, square_ypos);
      errors++;
    end
    ticks(24);
    checks++;
    if (square_xpos !== 10'd511 || square_ypos !== 10'd462) begin
      $display("FAIL pre_floor x=%0d y=%0d expected 511 462", square_xpos, square_ypos);
      errors++;
    end
    tick();
    checks++;
    if (square_xpos !== 10'd508 || square_ypos !== 10'd463) begin
      $display("FAIL floor_clamp x=%0d y=%0d expected 508 463", square_xpos, square_ypos);
      errors++;
    end
    tick();
    checks++;
    if (square_xpos !== 10'd505 || square_ypos !== 10'd461) begin
      $display("FAIL floor_up x=%0d y=%0d expected 505 461", square_xpos, square_ypos);
      errors++;
    end
    $display("test_wall_bounce: x=%0d y=%0d", square_xpos, square_ypos);
  endtask

  task automatic test_paddle1_bounce();
    ticks(157);
    checks++;
    if (square_xpos !== 10'd34 || square_ypos !== 10'd147) begin
      $display("FAIL pre_paddle1 x=%0d y=%0d expected 34 147", square_xpos, square_ypos);
      errors++;
    end
    tick();
    checks++;
    if (square_xpos !== 10'd33 || square_ypos !== 10'd145) begin
      $display("FAIL paddle1_hit x=%0d y=%0d expected 33 145", square_xpos, square_ypos);
      errors++;
    end
    tick();
    tick();
    checks++;
    if (square_xpos !== 10'd39 || square_ypos !== 10'd141) begin
      $display("FAIL after_paddle1 x=%0d y=%0d expected 39 141", square_xpos, square_ypos);
      errors++;
    end
    $display("test_paddle1_bounce: x=%0d y=%0d", square_xpos, square_ypos);
  endtask

  task automatic test_p1_point();
    paddle2_xpos = 10'd1023;
    ticks(194);
    checks++;
    if (square_xpos !== 10'd621 || square_ypos !== 10'd246 || point_p1 !== 1'b0) begin
      $display("FAIL pre_p1_point x=%0d y=%0d pulse=%0b expected 621 246 0", square_xpos, square_ypos, point_p1);
      errors++;
    end
    tick();
    checks++;
    if (point_p1 !== 1'b1 || point_p2 !== 1'b0 || score_p1 !== 4'd1 || sq_shown !== 1'b0) begin
      $display("FAIL p1_point pulse=%0b p2=%0b score=%0d shown=%0b expected 1 0 1 0", point_p1, point_p2, score_p1, sq_shown);
      errors++;
    end
    checks++;
    if (square_xpos !== 10'd621 || square_ypos !== 10'd246) begin
      $display("FAIL p1_point_freeze x=%0d y=%0d expected 621 246", square_xpos, square_ypos);
      errors++;
    end
    @(negedge clk_0);
    checks++;
    if (point_p1 !== 1'b0) begin
      $display("FAIL p1_pulse_width pulse=%0b expected 0", point_p1);
      errors++;
    end
    ticks(44);
    checks++;
    if (sq_shown !== 1'b0 || square_xpos !== 10'd621) begin
      $display("FAIL scored_hold shown=%0b x=%0d expected 0 621", sq_shown, square_xpos);
      errors++;
    end
    tick();
    checks++;
    if (sq_shown !== 1'b1 || square_xpos !== 10'd312 || square_ypos !== 10'd232) begin
      $display("FAIL scored_end shown=%0b x=%0d y=%0d expected 1 312 232", sq_shown, square_xpos, square_ypos);
      errors++;
    end
    $display("test_p1_point: score_p1=%0d score_p2=%0d", score_p1, score_p2);
  endtask

  task automatic test_p2_point();
    paddle1_ypos = 10'd0;
    paddle2_xpos = 10'd600;
    ticks(90);
    checks++;
    if (square_xpos !== 10'd583) begin
      $display("FAIL p2_round_paddle2 x=%0d expected 583", square_xpos);
      errors++;
    end
    ticks(194);
    checks++;
    if (square_xpos !== 10'd1 || square_ypos !== 10'd125) begin
      $display("FAIL pre_p2_point x=%0d y=%0d expected 1 125", square_xpos, square_ypos);
      errors++;
    end
    tick();
    checks++;
    if (point_p2 !== 1'b1 || point_p1 !== 1'b0 || score_p2 !== 4'd1 || score_p1 !== 4'd1 || sq_shown !== 1'b0) begin
      $display("FAIL p2_point pulse=%0b p1=%0b s2=%0d s1=%0d shown=%0b expected 1 0 1 1 0", point_p2, point_p1, score_p2, score_p1, sq_shown);
      errors++;
    end
    checks++;
    if (square_xpos !== 10'd1 || square_ypos !== 10'd125) begin
      $display("FAIL p2_point_freeze x=%0d y=%0d expected 1 125", square_xpos, square_ypos);
      errors++;
    end
    @(negedge clk_0);
    checks++;
    if (point_p2 !== 1'b0) begin
      $display("FAIL p2_pulse_width pulse=%0b expected 0", point_p2);
      errors++;
    end
    ticks(45);
    checks++;
    if (sq_shown !== 1'b1 || square_xpos !== 10'd312) begin
      $display("FAIL p2_scored_end shown=%0b x=%0d expected 1 312", sq_shown, square_xpos);
      errors++;
    end
    $display("test_p2_point: score_p1=%0d score_p2=%0d", score_p1, score_p2);
  endtask

  task automatic test_mid_play_reset();
    ticks(5);
    @(negedge clk_0);
    #5 rst = 1'b0;
    #1;
    checks++;
    if (square_xpos !== 10'd312 || square_ypos !== 10'd232 || sq_shown !== 1'b1 ||
        score_p1 !== 4'd0 || score_p2 !== 4'd0) begin
      $display("FAIL mid_play_reset x=%0d y=%0d shown=%0b s1=%0d s2=%0d expected 312 232 1 0 0",
               square_xpos, square_ypos, sq_shown, score_p1, score_p2);
      errors++;
    end
    @(negedge clk_0);
    rst = 1'b1;
    $display("test_mid_play_reset: x=%0d y=%0d", square_xpos, square_ypos);
  endtask

  task automatic test_score_saturation();
    logic [3:0] exp_score;
    paddle2_xpos = 10'd1023;
    for (int r = 1; r <= 16; r++) begin
      ticks((r == 1) ? 102 : 208);
      tick();
      exp_score = (r > 15) ? 4'd15 : 4'(r);
      checks++;
      if (point_p1 !== 1'b1 || score_p1 !== exp_score || square_xpos !== 10'd621) begin
        $display("FAIL sat_round%0d pulse=%0b score=%0d x=%0d expected 1 %0d 621", r, point_p1, score_p1, square_xpos, exp_score);
        errors++;
      end
      @(negedge clk_0);
      checks++;
      if (point_p1 !== 1'b0) begin
        $display("FAIL sat_pulse%0d pulse=%0b expected 0", r, point_p1);
        errors++;
      end
      $display("test_score_saturation: round=%0d score_p1=%0d", r, score_p1);
    end
  endtask

  task automatic test_mid_scored_reset();
    ticks(10);
    checks++;
    if (sq_shown !== 1'b0) begin
      $display("FAIL mid_scored_hidden shown=%0b expected 0", sq_shown);
      errors++;
    end
    #5 rst = 1'b0;
    #1;
    checks++;
    if (score_p1 !== 4'd0 || sq_shown !== 1'b1 || square_xpos !== 10'd312 || point_p1 !== 1'b0) begin
      $display("FAIL mid_scored_reset s1=%0d shown=%0b x=%0d pulse=%0b expected 0 1 312 0", score_p1, sq_shown, square_xpos, point_p1);
      errors++;
    end
    @(negedge clk_0);
    rst = 1'b1;
    $display("test_mid_scored_reset: score_p1=%0d shown=%0b", score_p1, sq_shown);
  endtask

  initial begin
    test_reset();
    test_serve(10'd315, 10'd234, "test_serve");
    test_wall_bounce();
    test_paddle1_bounce();
    test_p1_point();
    test_serve(10'd315, 10'd234, "test_reserve_right");
    test_p2_point();
    test_serve(10'd309, 10'd230, "test_reserve_left");
    test_mid_play_reset();
    test_serve(10'd315, 10'd234, "test_serve_after_reset");
    test_score_saturation();
    test_mid_scored_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
